// File: rtl/stage_fetch.sv
// rtl/stage_fetch.sv - IF stage: PC, one-outstanding instruction fetch, IF/ID register
//
// Purpose:
//   This module owns the PC. It fetches one instruction at a time from instruction
//   memory and loads the IF/ID register that feeds decode. It obeys hazard-unit stalls,
//   takes branch and exception redirects (an exception beats a branch), and fills IF/ID
//   with bubbles while no instruction is available.
//
// Ports:
//   clk, reset               clock; asynchronous active-low reset
//   in_pc_write_disable      hold PC (hazard unit)
//   in_IFID_write_disable    hold IF/ID register (hazard unit)
//   in_branch_taken/_target  branch redirect
//   in_exc_redirect/_target  exception redirect, beats branch
//   out_imem_req/_addr       fetch request; address is the PC
//   in_imem_rvalid/_rdata/_fault  fetch response
//   out_instruction/_PC/_valid/_exception_vector  IF/ID register contents
module stage_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_1000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_pc_write_disable,
   input  logic        in_IFID_write_disable,
   input  logic        in_branch_taken,
   input  logic [31:0] in_branch_target,
   input  logic        in_exc_redirect,
   input  logic [31:0] in_exc_target,
   output logic        out_imem_req,
   output logic [31:0] out_imem_addr,
   input  logic        in_imem_rvalid,
   input  logic [31:0] in_imem_rdata,
   input  logic        in_imem_fault,
   output logic [31:0] out_instruction,
   output logic [31:0] out_PC,
   output logic        out_valid,
   output logic [2:0]  out_exception_vector
);

   localparam logic [2:0] EXC_NONE     = 3'b000;
   localparam logic [2:0] EXC_MISALIGN = 3'b001;
   localparam logic [2:0] EXC_FAULT    = 3'b010;

   typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN, S_ERR} state_t;

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx, pc_plus4;
   logic [31:0] buf_data, buf_nx;
   logic        redirect, misaligned;
   logic [31:0] redirect_pc;

   // IF/ID load request; the load_* defaults describe a bubble
   logic        load;
   logic [31:0] load_instr, load_pc;
   logic        load_valid;
   logic [2:0]  load_exc;

   assign redirect    = in_exc_redirect | in_branch_taken;
   assign redirect_pc = in_exc_redirect ? in_exc_target : in_branch_target;
   assign misaligned  = |pc[1:0];
   assign pc_plus4    = pc + 32'd4;

   // Gated by reset so that no request is shown while reset is held
   assign out_imem_req  = reset && (state == S_FETCH) && !misaligned;
   assign out_imem_addr = pc;

   always_comb begin
      state_nx   = state;
      pc_nx      = pc;
      buf_nx     = buf_data;
      load       = 1'b0;
      load_instr = NOP_INSTR;
      load_pc    = 32'h0;
      load_valid = 1'b0;
      load_exc   = EXC_NONE;
      case (state)
         S_FETCH: begin
            if (redirect) begin
               pc_nx = redirect_pc;
               load  = 1'b1;
               // A request already issued must have its late response drained
               state_nx = (out_imem_req && !in_imem_rvalid) ? S_DRAIN : S_FETCH;
            end else if (misaligned) begin
               load       = 1'b1;
               load_pc    = pc;
               load_valid = 1'b1;
               load_exc   = EXC_MISALIGN;
               state_nx   = S_ERR;
            end else if (in_imem_rvalid && in_imem_fault) begin
               load       = 1'b1;
               load_pc    = pc;
               load_valid = 1'b1;
               load_exc   = EXC_FAULT;
               state_nx   = S_ERR;
            end else if (in_imem_rvalid) begin
               if (!in_IFID_write_disable) begin
                  load       = 1'b1;
                  load_instr = in_imem_rdata;
                  load_pc    = pc;
                  load_valid = 1'b1;
                  if (!in_pc_write_disable) pc_nx = pc_plus4;
               end else begin
                  // Decode is stalled: park the word; the PC still names it
                  buf_nx   = in_imem_rdata;
                  state_nx = S_HOLD;
               end
            end else begin
               load = !in_IFID_write_disable;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_nx    = redirect_pc;
               load     = 1'b1;
               state_nx = S_FETCH;
            end else if (!in_IFID_write_disable) begin
               load       = 1'b1;
               load_instr = buf_data;
               load_pc    = pc;
               load_valid = 1'b1;
               pc_nx      = pc_plus4;
               state_nx   = S_FETCH;
            end
         end
         S_DRAIN: begin
            load = redirect | !in_IFID_write_disable;
            if (redirect) pc_nx = redirect_pc;
            if (in_imem_rvalid) state_nx = S_FETCH;
         end
         S_ERR: begin
            load = 1'b1;
            if (redirect) begin
               pc_nx    = redirect_pc;
               state_nx = S_FETCH;
            end
         end
         default: state_nx = S_FETCH;
      endcase
      if (redirect) buf_nx = 32'h0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                <= S_FETCH;
         pc                   <= RESET_PC;
         buf_data             <= 32'h0;
         out_instruction      <= NOP_INSTR;
         out_PC               <= 32'h0;
         out_valid            <= 1'b0;
         out_exception_vector <= EXC_NONE;
      end else begin
         state    <= state_nx;
         pc       <= pc_nx;
         buf_data <= buf_nx;
         if (load) begin
            out_instruction      <= load_instr;
            out_PC               <= load_pc;
            out_valid            <= load_valid;
            out_exception_vector <= load_exc;
         end
      end
   end

endmodule

// File: tb/tb_stage_fetch.sv
// tb/tb_stage_fetch.sv - self-checking bench for stage_fetch
module tb_stage_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pcd = 1'b0, ifd = 1'b0, br = 1'b0, ex = 1'b0, rv = 1'b0, ft = 1'b0;
   logic [31:0] bt = 32'h0, et = 32'h0, rd = 32'h0;
   logic        out_imem_req, out_valid;
   logic [31:0] out_imem_addr, out_instruction, out_PC;
   logic [2:0]  out_exception_vector;

   int n_cmp = 0;
   int n_fail = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   stage_fetch dut (
      .clk                   (clk),
      .reset                 (reset),
      .in_pc_write_disable   (pcd),
      .in_IFID_write_disable (ifd),
      .in_branch_taken       (br),
      .in_branch_target      (bt),
      .in_exc_redirect       (ex),
      .in_exc_target         (et),
      .out_imem_req          (out_imem_req),
      .out_imem_addr         (out_imem_addr),
      .in_imem_rvalid        (rv),
      .in_imem_rdata         (rd),
      .in_imem_fault         (ft),
      .out_instruction       (out_instruction),
      .out_PC                (out_PC),
      .out_valid             (out_valid),
      .out_exception_vector  (out_exception_vector)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst, ifd, pcd, br, ex, rv, ft;
      logic [31:0] bt, et, rd;
      bit          e_req, e_val;
      logic [31:0] e_addr, e_pc, e_ins;
      logic [2:0]  e_ev;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] dat(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic add(input bit rst_i, ifd_i, pcd_i, br_i, input logic [31:0] bt_i,
                      input bit ex_i, input logic [31:0] et_i, input bit rv_i,
                      input logic [31:0] rd_i, input bit ft_i, input bit e_req_i,
                      input logic [31:0] e_addr_i, input bit e_val_i,
                      input logic [31:0] e_pc_i, e_ins_i, input logic [2:0] e_ev_i);
      vec_t v;
      v.rst = rst_i; v.ifd = ifd_i; v.pcd = pcd_i; v.br = br_i; v.bt = bt_i;
      v.ex = ex_i; v.et = et_i; v.rv = rv_i; v.rd = rd_i; v.ft = ft_i;
      v.e_req = e_req_i; v.e_addr = e_addr_i; v.e_val = e_val_i;
      v.e_pc = e_pc_i; v.e_ins = e_ins_i; v.e_ev = e_ev_i;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input bit ifd_i, pcd_i, br_i, input logic [31:0] bt_i,
                        input bit ex_i, input logic [31:0] et_i, input bit rv_i,
                        input logic [31:0] rd_i, input bit ft_i);
      ifd = ifd_i; pcd = pcd_i; br = br_i; bt = bt_i; ex = ex_i; et = et_i;
      rv = rv_i; rd = rd_i; ft = ft_i;
   endtask

   initial begin
      // rst ifd pcd br bt ex et rv rd ft | req addr val pc ins ev
      // Test 1: streaming fetch after reset
      add(1,0,0,0,0,0,0,0,0,0, 0,32'h1000,0,32'h0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'h1000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,1,dat(32'h1000),0, 1,32'h1000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,1,dat(32'h1004),0, 1,32'h1004,1,32'h1000,dat(32'h1000),3'd0);
      add(0,0,0,0,0,0,0,1,dat(32'h1008),0, 1,32'h1008,1,32'h1004,dat(32'h1004),3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'h100C,1,32'h1008,dat(32'h1008),3'd0);
      // Test 2: IF/ID stall while 0x1004 returns; stray rvalid in HOLD ignored
      add(1,0,0,0,0,0,0,0,0,0, 0,32'h1000,0,32'h0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'h1000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,1,dat(32'h1000),0, 1,32'h1000,0,0,NOP,3'd0);
      add(0,1,0,0,0,0,0,1,dat(32'h1004),0, 1,32'h1004,1,32'h1000,dat(32'h1000),3'd0);
      add(0,1,0,0,0,0,0,0,0,0, 0,32'h1004,1,32'h1000,dat(32'h1000),3'd0);
      add(0,1,0,0,0,0,0,1,32'hDEADBEEF,0, 0,32'h1004,1,32'h1000,dat(32'h1000),3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 0,32'h1004,1,32'h1000,dat(32'h1000),3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'h1008,1,32'h1004,dat(32'h1004),3'd0);
      // Test 3: branch to 0x2000 with 0x1008 outstanding
      add(0,0,0,1,32'h2000,0,0,0,0,0, 1,32'h1008,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 0,32'h2000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,1,dat(32'h1008),0, 0,32'h2000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'h2000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,1,dat(32'h2000),0, 1,32'h2000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'h2004,1,32'h2000,dat(32'h2000),3'd0);
      // Test 4: branch and exception together, same-cycle response discarded
      add(0,0,0,1,32'h3000,1,32'h8000,1,dat(32'h2004),0, 1,32'h2004,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'h8000,0,0,NOP,3'd0);
      // Test 5: branch to misaligned 0x2002
      add(0,0,0,1,32'h2002,0,0,1,dat(32'h8000),0, 1,32'h8000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 0,32'h2002,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 0,32'h2002,1,32'h2002,NOP,3'd1);
      add(0,0,0,0,0,0,0,0,0,0, 0,32'h2002,0,0,NOP,3'd0);
      add(0,0,0,0,0,1,32'h8000,0,0,0, 0,32'h2002,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'h8000,0,0,NOP,3'd0);
      // Test 6: access fault, then reset asserted in DRAIN
      add(1,0,0,0,0,0,0,0,0,0, 0,32'h1000,0,32'h0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'h1000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,1,32'h0,1, 1,32'h1000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 0,32'h1000,1,32'h1000,NOP,3'd2);
      add(0,0,0,0,0,1,32'h8000,0,0,0, 0,32'h1000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'h8000,0,0,NOP,3'd0);
      add(0,0,0,1,32'h9000,0,0,0,0,0, 1,32'h8000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 0,32'h9000,0,0,NOP,3'd0);
      add(1,0,0,0,0,0,0,0,0,0, 0,32'h1000,0,32'h0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'h1000,0,0,NOP,3'd0);
      // PC wrap at the top of the address space, then a PC hold
      add(0,0,0,1,32'hFFFF_FFFC,0,0,0,0,0, 1,32'h1000,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,1,32'h0,0, 0,32'hFFFF_FFFC,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'hFFFF_FFFC,0,0,NOP,3'd0);
      add(0,0,0,0,0,0,0,1,32'hC0DE_FFFC,0, 1,32'hFFFF_FFFC,0,0,NOP,3'd0);
      add(0,0,1,0,0,0,0,1,32'hC0DE_0000,0, 1,32'h0,1,32'hFFFF_FFFC,32'hC0DE_FFFC,3'd0);
      add(0,0,0,0,0,0,0,0,0,0, 1,32'h0,1,32'h0,32'hC0DE_0000,3'd0);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset = !vecs[i].rst;
         drive(vecs[i].ifd, vecs[i].pcd, vecs[i].br, vecs[i].bt, vecs[i].ex,
               vecs[i].et, vecs[i].rv, vecs[i].rd, vecs[i].ft);
         #1;
         check("req", i, out_imem_req, vecs[i].e_req);
         check("addr", i, out_imem_addr, vecs[i].e_addr);
         check("valid", i, out_valid, vecs[i].e_val);
         check("instr", i, out_instruction, vecs[i].e_ins);
         check("excvec", i, out_exception_vector, vecs[i].e_ev);
         if (vecs[i].e_val || vecs[i].rst)
            check("pc", i, out_PC, vecs[i].e_pc);
      end

      // Second redirect while draining updates the PC only
      @(negedge clk); drive(0,0,1,32'h4000,0,0,0,0,0); #1;
      check("h_req0", 100, out_imem_req, 1'b1);
      check("h_addr0", 100, out_imem_addr, 32'h0);
      @(negedge clk); drive(0,0,1,32'h5000,0,0,0,0,0); #1;
      check("h_req1", 101, out_imem_req, 1'b0);
      check("h_addr1", 101, out_imem_addr, 32'h4000);
      @(negedge clk); drive(0,0,0,0,0,0,1,32'hBAD0_BAD0,0); #1;
      check("h_req2", 102, out_imem_req, 1'b0);
      check("h_addr2", 102, out_imem_addr, 32'h5000);
      @(negedge clk); drive(0,0,0,0,0,0,0,0,0); #1;
      begin
         int waited = 0;
         while (!out_imem_req && waited < 8) begin
            @(negedge clk); #1;
            waited++;
         end
         check("h_req_timeout", 103, out_imem_req, 1'b1);
      end
      check("h_addr3", 103, out_imem_addr, 32'h5000);
      check("h_valid3", 103, out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
